// File: rtl/pio_irq_service_master.sv
// pio_irq_service_master
// ----------------------
// Avalon-MM initiator that services an edge-capturing input PIO slave
// (data register at address 0, irq mask at 2, edge capture at 3).
// After reset it writes INIT_MASK into the mask register. On each irq it
// reads the edge capture register, write-1-clears exactly the bits it read,
// then samples the data register. It presents one {edges, levels} event
// per service on a valid/ready stream.
//
// Event handshake: event_valid, event_edges, event_level (and event_time)
// are held stable from the cycle event_valid rises until a cycle where
// event_valid & event_ready are both high. That cycle is the transfer, and
// event_valid falls on the following cycle. irq is ignored while
// event_valid is high.
//
// Optional feature (macro PIO_SERVICE_TIMESTAMP_EN): adds a free-running
// 32-bit cycle counter, latched when a service starts and presented on
// event_time together with the event.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   irq               slave interrupt (level)
//   address, chipselect, write_n, writedata, readdata   slave s1 bus
//   event_valid, event_ready, event_edges, event_level  event stream
//   event_time        service start time (timestamp build only)
//   init_done         mask write has completed
//   busy              registered image of "FSM not in IDLE"
//   state             FSM state for debug
//                     (0 INIT, 1 IDLE, 2 RD_EDGE, 3 CLR, 4 RD_DATA, 5 EMIT)
module pio_irq_service_master #(
    parameter int               WIDTH        = 2,
    parameter logic [WIDTH-1:0] INIT_MASK    = 2'b11,
    parameter int               READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             irq,
    output logic [1:0]       address,
    output logic             chipselect,
    output logic             write_n,
    output logic [31:0]      writedata,
    input  logic [31:0]      readdata,
    output logic             event_valid,
    input  logic             event_ready,
    output logic [WIDTH-1:0] event_edges,
    output logic [WIDTH-1:0] event_level,
    output logic             init_done,
    output logic             busy,
`ifdef PIO_SERVICE_TIMESTAMP_EN
    output logic [31:0]      event_time,
`endif
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_RD_EDGE = 3'd2,
        S_CLR     = 3'd3,
        S_RD_DATA = 3'd4,
        S_EMIT    = 3'd5
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;
    // A read holds the address for READ_LATENCY+1 cycles; the counter runs
    // 0..READ_LATENCY and readdata is captured when it reaches the end.
    localparam logic [1:0] RD_LAST   = 2'(READ_LATENCY);

    state_t           cur_state;
    logic [1:0]       wait_cnt;
    logic [WIDTH-1:0] edge_reg;

    assign state = cur_state;

`ifdef PIO_SERVICE_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt <= 32'd0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state   <= S_INIT;
            address     <= ADDR_DATA;
            chipselect  <= 1'b0;
            write_n     <= 1'b1;
            writedata   <= 32'd0;
            event_valid <= 1'b0;
            event_edges <= '0;
            event_level <= '0;
            init_done   <= 1'b0;
            busy        <= 1'b1;
            wait_cnt    <= 2'd0;
            edge_reg    <= '0;
`ifdef PIO_SERVICE_TIMESTAMP_EN
            ts_start    <= 32'd0;
            event_time  <= 32'd0;
`endif
        end else begin
            busy <= (cur_state != S_IDLE);

            if (event_valid && event_ready) begin
                event_valid <= 1'b0;
            end

            case (cur_state)
                S_INIT: begin
                    // First cycle out of reset launches the mask write; the
                    // next cycle (write visible on the bus) retires it.
                    if (write_n) begin
                        chipselect <= 1'b1;
                        write_n    <= 1'b0;
                        address    <= ADDR_MASK;
                        writedata  <= 32'(INIT_MASK);
                    end else begin
                        chipselect <= 1'b0;
                        write_n    <= 1'b1;
                        address    <= ADDR_DATA;
                        writedata  <= 32'd0;
                        init_done  <= 1'b1;
                        cur_state  <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    // Uses the registered event_valid, so the transfer cycle
                    // itself still blocks a new service (one-cycle gap).
                    if (irq && !event_valid) begin
                        chipselect <= 1'b1;
                        write_n    <= 1'b1;
                        address    <= ADDR_EDGE;
                        wait_cnt   <= 2'd0;
                        cur_state  <= S_RD_EDGE;
`ifdef PIO_SERVICE_TIMESTAMP_EN
                        ts_start   <= ts_cnt;
`endif
                    end
                end

                S_RD_EDGE: begin
                    if (wait_cnt == RD_LAST) begin
                        edge_reg <= readdata[WIDTH-1:0];
                        if (readdata[WIDTH-1:0] == '0) begin
                            // Spurious or already-cleared interrupt.
                            chipselect <= 1'b0;
                            address    <= ADDR_DATA;
                            cur_state  <= S_IDLE;
                        end else begin
                            // Clear only what was read, so edges arriving
                            // meanwhile on other bits keep irq asserted.
                            write_n   <= 1'b0;
                            writedata <= 32'(readdata[WIDTH-1:0]);
                            cur_state <= S_CLR;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end

                S_CLR: begin
                    write_n   <= 1'b1;
                    writedata <= 32'd0;
                    address   <= ADDR_DATA;
                    wait_cnt  <= 2'd0;
                    cur_state <= S_RD_DATA;
                end

                S_RD_DATA: begin
                    if (wait_cnt == RD_LAST) begin
                        event_level <= readdata[WIDTH-1:0];
                        chipselect  <= 1'b0;
                        cur_state   <= S_EMIT;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end

                S_EMIT: begin
                    event_edges <= edge_reg;
                    event_valid <= 1'b1;
`ifdef PIO_SERVICE_TIMESTAMP_EN
                    event_time  <= ts_start;
`endif
                    cur_state   <= S_IDLE;
                end

                default: begin
                    cur_state <= S_INIT;
                end
            endcase
        end
    end

    // Upper readdata bits carry nothing for this block.
    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_upper;
            assign unused_upper = ^readdata[31:WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_pio_irq_service_master.sv
// Directed testbench for pio_irq_service_master (WIDTH=2, INIT_MASK=2'b11,
// READ_LATENCY=1) against a small behavioural model of the PIO slave.
`timescale 1ns/1ps
module tb_pio_irq_service_master;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        irq;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata = 32'd0;
    logic        event_valid;
    logic        event_ready = 1'b0;
    logic [1:0]  event_edges;
    logic [1:0]  event_level;
    logic        init_done;
    logic        busy;
    logic [2:0]  state;
`ifdef PIO_SERVICE_TIMESTAMP_EN
    logic [31:0] event_time;
`endif

    pio_irq_service_master #(
        .WIDTH(2),
        .INIT_MASK(2'b11),
        .READ_LATENCY(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .irq(irq),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .event_valid(event_valid),
        .event_ready(event_ready),
        .event_edges(event_edges),
        .event_level(event_level),
        .init_done(init_done),
        .busy(busy),
`ifdef PIO_SERVICE_TIMESTAMP_EN
        .event_time(event_time),
`endif
        .state(state)
    );

    // ---------------- PIO slave model ----------------
    logic [1:0] edge_cap  = 2'b00;
    logic [1:0] mask_reg  = 2'b00;
    logic [1:0] in_port   = 2'b00;
    logic [1:0] inject    = 2'b00;
    logic       irq_force = 1'b0;

    assign irq = (|(edge_cap & mask_reg)) | irq_force;

    always @(posedge clk) begin
        if (chipselect && !write_n && address == 2'd2) mask_reg <= writedata[1:0];
        edge_cap <= (edge_cap & ~((chipselect && !write_n && address == 2'd3) ? writedata[1:0] : 2'b00)) | inject;
        // Registered read, one cycle latency; junk in the upper bits.
        case (address)
            2'd0:    readdata <= {30'h15A5A5A5, in_port};
            2'd2:    readdata <= {30'h15A5A5A5, mask_reg};
            2'd3:    readdata <= {30'h15A5A5A5, edge_cap};
            default: readdata <= {30'h15A5A5A5, 2'b00};
        endcase
    end

    // ---------------- bus / stream monitor ----------------
    int         cyc = 0;
    int         wr_cnt = 0;
    int         rd3_cnt = 0;
    int         rd0_cnt = 0;
    int         ev_cnt = 0;
    logic [1:0]  last_wr_addr = 2'd0;
    logic [31:0] last_wr_data = 32'd0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (chipselect && !write_n) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= address;
            last_wr_data <= writedata;
        end
        if (chipselect && write_n && address == 2'd3) rd3_cnt <= rd3_cnt + 1;
        if (chipselect && write_n && address == 2'd0) rd0_cnt <= rd0_cnt + 1;
        if (event_valid && event_ready) ev_cnt <= ev_cnt + 1;
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad = 0;

    // ---------------- driver tasks ----------------
    task automatic inject_edges(input logic [1:0] bits);
        inject = bits;
        @(negedge clk);
        inject = 2'b00;
    endtask

    task automatic wait_event(input int limit, output bit ok);
        int n;
        n = 0;
        while (!event_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = event_valid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int w0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        if ({chipselect, write_n, address} !== 4'b0100) begin bad++; $display("FAIL reset_bus got cs/wn/addr=%b want 0100", {chipselect, write_n, address}); end total++;
        if (writedata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h want=0", writedata); end total++;
        if ({event_valid, event_edges, event_level} !== 5'b0) begin bad++; $display("FAIL reset_event got=%b want=00000", {event_valid, event_edges, event_level}); end total++;
        if ({init_done, busy} !== 2'b01) begin bad++; $display("FAIL reset_status got init/busy=%b want=01", {init_done, busy}); end total++;
        if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end total++;
        w0 = wr_cnt;
        reset_n = 1'b1;
        @(negedge clk);
        if ({chipselect, write_n, address} !== 4'b1010) begin bad++; $display("FAIL init_write_bus got cs/wn/addr=%b want 1010", {chipselect, write_n, address}); end total++;
        if (writedata !== 32'h3) begin bad++; $display("FAIL init_write_data got=%h want=3", writedata); end total++;
        if (init_done !== 1'b0) begin bad++; $display("FAIL init_done_early got=%b want=0", init_done); end total++;
        @(negedge clk);
        if ({chipselect, write_n, init_done, busy} !== 4'b0111) begin bad++; $display("FAIL init_next got cs/wn/done/busy=%b want 0111", {chipselect, write_n, init_done, busy}); end total++;
        @(negedge clk);
        if ({init_done, busy} !== 2'b10) begin bad++; $display("FAIL init_idle got done/busy=%b want 10", {init_done, busy}); end total++;
        repeat (3) @(negedge clk);
        if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL init_write_count got=%0d want=1", wr_cnt - w0); end total++;
        if (mask_reg !== 2'b11) begin bad++; $display("FAIL init_mask got=%b want=11", mask_reg); end total++;
    endtask

    task automatic test_single();
        int w0, r3, r0, e0, t0;
        bit ok;
        in_port = 2'b01;
        event_ready = 1'b1;
        w0 = wr_cnt; r3 = rd3_cnt; r0 = rd0_cnt; e0 = ev_cnt;
        inject_edges(2'b01);
        t0 = cyc;
        if (irq !== 1'b1) begin bad++; $display("FAIL single_irq got=%b want=1", irq); end total++;
        wait_event(20, ok);
        if (ok !== 1'b1) begin bad++; $display("FAIL single_timeout got valid=%b want=1", ok); end total++;
        if (cyc - t0 !== 7) begin bad++; $display("FAIL single_latency got=%0d want=7", cyc - t0); end total++;
        if (event_edges !== 2'b01) begin bad++; $display("FAIL single_edges got=%b want=01", event_edges); end total++;
        if (event_level !== 2'b01) begin bad++; $display("FAIL single_level got=%b want=01", event_level); end total++;
        @(negedge clk);
        if (event_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got valid=%b want=0", event_valid); end total++;
        repeat (3) @(negedge clk);
        if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL single_wr_count got=%0d want=1", wr_cnt - w0); end total++;
        if ({last_wr_addr, last_wr_data} !== {2'd3, 32'h1}) begin bad++; $display("FAIL single_clr got addr=%0d data=%h want addr=3 data=1", last_wr_addr, last_wr_data); end total++;
        if (rd3_cnt - r3 !== 2) begin bad++; $display("FAIL single_rd_edge_cycles got=%0d want=2", rd3_cnt - r3); end total++;
        if (rd0_cnt - r0 !== 2) begin bad++; $display("FAIL single_rd_data_cycles got=%0d want=2", rd0_cnt - r0); end total++;
        if (ev_cnt - e0 !== 1) begin bad++; $display("FAIL single_ev_count got=%0d want=1", ev_cnt - e0); end total++;
        if ({edge_cap, busy, state} !== {2'b00, 1'b0, 3'd1}) begin bad++; $display("FAIL single_after got edge/busy/state=%b want 000001", {edge_cap, busy, state}); end total++;
    endtask

    task automatic test_edge_during_clr();
        int w0, e0, t0;
        bit ok;
        in_port = 2'b11;
        event_ready = 1'b1;
        w0 = wr_cnt; e0 = ev_cnt;
        inject_edges(2'b01);
        t0 = cyc;
        repeat (3) @(negedge clk);
        if ({chipselect, write_n, address, writedata} !== {1'b1, 1'b0, 2'd3, 32'h1}) begin bad++; $display("FAIL clr_cycle got cs/wn/addr=%b wd=%h want 1011 wd=1", {chipselect, write_n, address}, writedata); end total++;
        inject_edges(2'b10);
        wait_event(20, ok);
        if (ok !== 1'b1) begin bad++; $display("FAIL clr_first_timeout got valid=%b want=1", ok); end total++;
        if (event_edges !== 2'b01) begin bad++; $display("FAIL clr_first_edges got=%b want=01", event_edges); end total++;
        if ({irq, edge_cap} !== 3'b110) begin bad++; $display("FAIL clr_survivor got irq/edge=%b want 110", {irq, edge_cap}); end total++;
        @(negedge clk);
        wait_event(20, ok);
        if (ok !== 1'b1) begin bad++; $display("FAIL clr_second_timeout got valid=%b want=1", ok); end total++;
        if (cyc - t0 !== 15) begin bad++; $display("FAIL clr_second_time got=%0d want=15", cyc - t0); end total++;
        if ({event_edges, event_level} !== 4'b1011) begin bad++; $display("FAIL clr_second_event got edges/level=%b want 1011", {event_edges, event_level}); end total++;
        repeat (4) @(negedge clk);
        if (ev_cnt - e0 !== 2) begin bad++; $display("FAIL clr_ev_count got=%0d want=2", ev_cnt - e0); end total++;
        if (wr_cnt - w0 !== 2) begin bad++; $display("FAIL clr_wr_count got=%0d want=2", wr_cnt - w0); end total++;
        if (edge_cap !== 2'b00) begin bad++; $display("FAIL clr_drained got=%b want=00", edge_cap); end total++;
    endtask

    task automatic test_backpressure();
        int w0, e0, th;
        bit ok;
        in_port = 2'b01;
        event_ready = 1'b0;
        e0 = ev_cnt;
        inject_edges(2'b01);
        wait_event(20, ok);
        if (ok !== 1'b1) begin bad++; $display("FAIL bp_first_timeout got valid=%b want=1", ok); end total++;
        w0 = wr_cnt;
        in_port = 2'b10;
        for (int i = 0; i < 20; i++) begin
            inject = (i == 3) ? 2'b11 : ((i == 9) ? 2'b10 : 2'b00);
            @(negedge clk);
            if ({event_valid, event_edges, event_level, chipselect} !== 6'b101010) begin
                bad++;
                $display("FAIL bp_hold[%0d] got valid/edges/level/cs=%b want 101010", i, {event_valid, event_edges, event_level, chipselect});
            end
            total++;
        end
        inject = 2'b00;
        if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL bp_no_writes got=%0d want=0", wr_cnt - w0); end total++;
        if ({irq, edge_cap} !== 3'b111) begin bad++; $display("FAIL bp_accum got irq/edge=%b want 111", {irq, edge_cap}); end total++;
        event_ready = 1'b1;
        @(negedge clk);
        th = cyc;
        if (event_valid !== 1'b0) begin bad++; $display("FAIL bp_release got valid=%b want=0", event_valid); end total++;
        wait_event(20, ok);
        if (ok !== 1'b1) begin bad++; $display("FAIL bp_second_timeout got valid=%b want=1", ok); end total++;
        if (cyc - th !== 7) begin bad++; $display("FAIL bp_second_latency got=%0d want=7", cyc - th); end total++;
        if ({event_edges, event_level} !== 4'b1110) begin bad++; $display("FAIL bp_second_event got edges/level=%b want 1110", {event_edges, event_level}); end total++;
        repeat (3) @(negedge clk);
        if (ev_cnt - e0 !== 2) begin bad++; $display("FAIL bp_ev_count got=%0d want=2", ev_cnt - e0); end total++;
    endtask

    task automatic test_spurious();
        int w0, r3, r0, e0;
        w0 = wr_cnt; r3 = rd3_cnt; r0 = rd0_cnt; e0 = ev_cnt;
        event_ready = 1'b1;
        irq_force = 1'b1;
        @(negedge clk);
        irq_force = 1'b0;
        repeat (12) @(negedge clk);
        if (rd3_cnt - r3 !== 2) begin bad++; $display("FAIL spur_rd_edge got=%0d want=2", rd3_cnt - r3); end total++;
        if (rd0_cnt - r0 !== 0) begin bad++; $display("FAIL spur_rd_data got=%0d want=0", rd0_cnt - r0); end total++;
        if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL spur_writes got=%0d want=0", wr_cnt - w0); end total++;
        if (ev_cnt - e0 !== 0) begin bad++; $display("FAIL spur_events got=%0d want=0", ev_cnt - e0); end total++;
        if ({event_valid, busy, state} !== {1'b0, 1'b0, 3'd1}) begin bad++; $display("FAIL spur_idle got valid/busy/state=%b want 00001", {event_valid, busy, state}); end total++;
    endtask

    task automatic test_reset_mid_clr();
        int w0, e0;
        bit ok;
        in_port = 2'b01;
        event_ready = 1'b1;
        inject_edges(2'b01);
        repeat (3) @(negedge clk);
        if ({chipselect, write_n, address} !== 4'b1011) begin bad++; $display("FAIL rst_clr_cycle got cs/wn/addr=%b want 1011", {chipselect, write_n, address}); end total++;
        w0 = wr_cnt; e0 = ev_cnt;
        reset_n = 1'b0;
        #1;
        if ({chipselect, write_n} !== 2'b01) begin bad++; $display("FAIL rst_async_bus got cs/wn=%b want 01", {chipselect, write_n}); end total++;
        if ({state, init_done, event_valid} !== 5'b00000) begin bad++; $display("FAIL rst_async_state got state/done/valid=%b want 00000", {state, init_done, event_valid}); end total++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        if ({chipselect, write_n, address, writedata} !== {1'b1, 1'b0, 2'd2, 32'h3}) begin bad++; $display("FAIL rst_reinit got cs/wn/addr=%b wd=%h want 1010 wd=3", {chipselect, write_n, address}, writedata); end total++;
        if (event_valid !== 1'b0) begin bad++; $display("FAIL rst_no_event got=%b want=0", event_valid); end total++;
        if (edge_cap !== 2'b01) begin bad++; $display("FAIL rst_no_clear got=%b want=01", edge_cap); end total++;
        wait_event(30, ok);
        if (ok !== 1'b1) begin bad++; $display("FAIL rst_resume_timeout got valid=%b want=1", ok); end total++;
        if ({event_edges, event_level} !== 4'b0101) begin bad++; $display("FAIL rst_resume_event got edges/level=%b want 0101", {event_edges, event_level}); end total++;
        repeat (3) @(negedge clk);
        if (wr_cnt - w0 !== 2) begin bad++; $display("FAIL rst_wr_count got=%0d want=2", wr_cnt - w0); end total++;
        if (ev_cnt - e0 !== 1) begin bad++; $display("FAIL rst_ev_count got=%0d want=1", ev_cnt - e0); end total++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single();
        test_edge_during_clr();
        test_backpressure();
        test_spurious();
        test_reset_mid_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a wait never returns.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
